// File: rtl/inst_fetch_sramlike_pkg.sv
// Shared types and constants for the sram-like instruction fetch front end.
//   RESET_PC_DEFAULT : default PC after reset (first fetch address)
//   SIZE_WORD        : sram-like size code for a 32-bit transfer
//   if_state_e       : fetch FSM states (IF_REQ / IF_WAIT / IF_FULL)
//   fetch_entry_t    : {pc, instruction} pair carried from bus to decode
package inst_fetch_sramlike_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam logic [1:0]  SIZE_WORD        = 2'b10;

    typedef enum logic [1:0] {
        IF_REQ  = 2'd0,
        IF_WAIT = 2'd1,
        IF_FULL = 2'd2
    } if_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_sramlike_fetch_buffer.sv
// Output register (OUT) plus one skid entry between the instruction bus and
// decode. Returned data cannot be back-pressured, so a word arriving while
// OUT is held by a stalled decode is parked in the skid entry.
//   clk, rstn   : clock, asynchronous active-low reset
//   push        : push_entry is written (into OUT if free/consumed, else skid)
//   pop         : OUT is consumed by decode this cycle
//   flush       : drop both OUT and skid (redirect)
//   out_entry   : {pc, instruction} presented to decode
//   out_valid   : out_entry is valid
//   full        : skid entry occupied
module inst_fetch_sramlike_fetch_buffer
    import inst_fetch_sramlike_pkg::*;
(
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t out_entry,
    output logic         out_valid,
    output logic         full
);

    fetch_entry_t skid_p0;
    logic         skid_vld_p0;
    fetch_entry_t out_p1;
    logic         out_vld_p1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            skid_p0     <= '0;
            skid_vld_p0 <= 1'b0;
            out_p1      <= '0;
            out_vld_p1  <= 1'b0;
        end else if (flush) begin
            skid_vld_p0 <= 1'b0;
            out_vld_p1  <= 1'b0;
        end else if (pop && skid_vld_p0) begin
            // Skid drains into OUT; the FSM never pushes while the skid is full.
            out_p1      <= skid_p0;
            out_vld_p1  <= 1'b1;
            skid_vld_p0 <= 1'b0;
        end else if (push && (!out_vld_p1 || pop)) begin
            out_p1     <= push_entry;
            out_vld_p1 <= 1'b1;
        end else if (push) begin
            skid_p0     <= push_entry;
            skid_vld_p0 <= 1'b1;
        end else if (pop) begin
            out_vld_p1 <= 1'b0;
        end
    end

    assign out_entry = out_p1;
    assign out_valid = out_vld_p1;
    assign full      = skid_vld_p0;

endmodule

// File: rtl/inst_fetch_sramlike.sv
// Instruction fetch front end: owns the PC, issues one outstanding request
// at a time on the sram-like instruction bus and hands {pc, instruction,
// valid} to decode. Redirects steer the PC and kill in-flight/buffered words.
//   clk, rstn                  : clock, asynchronous active-low reset
//   stall                      : decode cannot accept the current output
//   redirect, redirect_pc      : one-cycle PC steer from decode/branch logic
//   inst_req/wr/size/addr      : sram-like request side
//   inst_rdata/addr_ok/data_ok : sram-like response side
//   pc_out, instruction,
//   inst_valid                 : instruction presented to decode
module inst_fetch_sramlike
    import inst_fetch_sramlike_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_req,
    output logic        inst_wr,
    output logic [1:0]  inst_size,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst_rdata,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    output logic [31:0] pc_out,
    output logic [31:0] instruction,
    output logic        inst_valid
);

    if_state_e    state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  req_pc_q, req_pc_d;   // PC of the outstanding request
    logic         discard_q, discard_d; // outstanding request is wrong-path
    logic         consume;
    logic         buf_push, buf_flush, buf_full;
    fetch_entry_t buf_out;

    assign consume = inst_valid && !stall && !redirect;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IF_REQ;
            pc_q      <= RESET_PC;
            req_pc_q  <= '0;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            req_pc_q  <= req_pc_d;
            discard_q <= discard_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        req_pc_d  = req_pc_q;
        discard_d = discard_q;
        buf_push  = 1'b0;
        buf_flush = 1'b0;
        case (state_q)
            IF_REQ: begin
                buf_flush = redirect;
                if (inst_addr_ok) begin
                    req_pc_d  = pc_q;
                    discard_d = redirect;
                    pc_d      = redirect ? redirect_pc : pc_q + PC_STEP;
                    state_d   = IF_WAIT;
                end else if (redirect) begin
                    pc_d = redirect_pc;
                end
            end
            IF_WAIT: begin
                if (inst_data_ok) begin
                    state_d   = IF_REQ;
                    discard_d = 1'b0;
                    if (discard_q || redirect) begin
                        if (redirect) begin
                            pc_d      = redirect_pc;
                            buf_flush = 1'b1;
                        end
                    end else begin
                        buf_push = 1'b1;
                        // OUT still held by decode: the word lands in the skid.
                        if (inst_valid && !consume) begin
                            state_d = IF_FULL;
                        end
                    end
                end else if (redirect) begin
                    pc_d      = redirect_pc;
                    discard_d = 1'b1;
                    buf_flush = 1'b1;
                end
            end
            IF_FULL: begin
                if (redirect) begin
                    pc_d      = redirect_pc;
                    buf_flush = 1'b1;
                    state_d   = IF_REQ;
                end else if (consume) begin
                    state_d = IF_REQ;
                end
            end
            default: state_d = IF_REQ;
        endcase
    end

    inst_fetch_sramlike_fetch_buffer u_fetch_buffer (
        .clk        (clk),
        .rstn       (rstn),
        .push       (buf_push),
        .push_entry ({req_pc_q, inst_rdata}),
        .pop        (consume),
        .flush      (buf_flush),
        .out_entry  (buf_out),
        .out_valid  (inst_valid),
        .full       (buf_full)
    );

    // The skid check keeps a request from ever leaving while a word is parked.
    assign inst_req    = (state_q == IF_REQ) && !buf_full;
    assign inst_wr     = 1'b0;
    assign inst_size   = SIZE_WORD;
    assign inst_addr   = pc_q;
    assign pc_out      = buf_out.pc;
    assign instruction = buf_out.inst;

endmodule

// File: tb/tb_inst_fetch_sramlike.sv
module tb_inst_fetch_sramlike;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_req;
    logic        inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata = '0;
    logic        inst_addr_ok = 1'b0;
    logic        inst_data_ok = 1'b0;
    logic [31:0] pc_out;
    logic [31:0] instruction;
    logic        inst_valid;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        st;
        logic        rd;
        logic [31:0] rpc;
        logic        aok;
        logic        dok;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_pc;
        logic [31:0] e_ins;
    } vec_t;

    vec_t vecs[$];

    inst_fetch_sramlike dut (
        .clk          (clk),
        .rstn         (rstn),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_addr    (inst_addr),
        .inst_rdata   (inst_rdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .pc_out       (pc_out),
        .instruction  (instruction),
        .inst_valid   (inst_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic ereq, input logic [31:0] eaddr,
                              input logic evld, input logic [31:0] epc, input logic [31:0] eins);
        chk({tag, " inst_req"}, {31'd0, inst_req}, {31'd0, ereq});
        chk({tag, " inst_addr"}, inst_addr, eaddr);
        chk({tag, " inst_valid"}, {31'd0, inst_valid}, {31'd0, evld});
        if (evld) begin
            chk({tag, " pc_out"}, pc_out, epc);
            chk({tag, " instruction"}, instruction, eins);
        end
    endtask

    task automatic drive(input logic st, input logic rd, input logic [31:0] rpc,
                         input logic aok, input logic dok, input logic [31:0] rdata);
        stall        = st;
        redirect     = rd;
        redirect_pc  = rpc;
        inst_addr_ok = aok;
        inst_data_ok = dok;
        inst_rdata   = rdata;
    endtask

    task automatic step(input logic st, input logic rd, input logic [31:0] rpc,
                        input logic aok, input logic dok, input logic [31:0] rdata);
        drive(st, rd, rpc, aok, dok, rdata);
        @(negedge clk);
    endtask

    task automatic add(input logic st, input logic rd, input logic [31:0] rpc,
                       input logic aok, input logic dok, input logic [31:0] rdata,
                       input logic ereq, input logic [31:0] eaddr, input logic evld,
                       input logic [31:0] epc, input logic [31:0] eins);
        vec_t v;
        v.st = st; v.rd = rd; v.rpc = rpc; v.aok = aok; v.dok = dok; v.rdata = rdata;
        v.e_req = ereq; v.e_addr = eaddr; v.e_vld = evld; v.e_pc = epc; v.e_ins = eins;
        vecs.push_back(v);
    endtask

    initial begin
        // Per row: inputs for this cycle, outputs expected during this cycle.
        //  st rd rpc           aok dok rdata          req addr          vld pc            ins
        // Zero-wait fetch stream, then a 5-cycle stall that fills the skid.
        add(0, 0, 0,            1, 0, 0,             1, 32'hBFC00000, 0, 0,            0);
        add(0, 0, 0,            0, 1, 32'h11110000,  0, 32'hBFC00004, 0, 0,            0);
        add(0, 0, 0,            1, 0, 0,             1, 32'hBFC00004, 1, 32'hBFC00000, 32'h11110000);
        add(0, 0, 0,            0, 1, 32'h11110001,  0, 32'hBFC00008, 0, 0,            0);
        add(1, 0, 0,            1, 0, 0,             1, 32'hBFC00008, 1, 32'hBFC00004, 32'h11110001);
        add(1, 0, 0,            0, 1, 32'h11110002,  0, 32'hBFC0000C, 1, 32'hBFC00004, 32'h11110001);
        add(1, 0, 0,            0, 0, 0,             0, 32'hBFC0000C, 1, 32'hBFC00004, 32'h11110001);
        add(1, 0, 0,            0, 0, 0,             0, 32'hBFC0000C, 1, 32'hBFC00004, 32'h11110001);
        add(1, 0, 0,            0, 0, 0,             0, 32'hBFC0000C, 1, 32'hBFC00004, 32'h11110001);
        add(0, 0, 0,            0, 0, 0,             0, 32'hBFC0000C, 1, 32'hBFC00004, 32'h11110001);
        add(0, 0, 0,            0, 0, 0,             1, 32'hBFC0000C, 1, 32'hBFC00008, 32'h11110002);
        add(0, 0, 0,            0, 0, 0,             1, 32'hBFC0000C, 0, 0,            0);
        // Redirect coincident with addr_ok at BFC00010: that word is wrong-path.
        add(0, 0, 0,            1, 0, 0,             1, 32'hBFC0000C, 0, 0,            0);
        add(0, 0, 0,            0, 1, 32'h11110003,  0, 32'hBFC00010, 0, 0,            0);
        add(0, 1, 32'h80000100, 1, 0, 0,             1, 32'hBFC00010, 1, 32'hBFC0000C, 32'h11110003);
        add(0, 0, 0,            0, 1, 32'hBAD00010,  0, 32'h80000100, 0, 0,            0);
        // Redirect while waiting for data.
        add(0, 0, 0,            1, 0, 0,             1, 32'h80000100, 0, 0,            0);
        add(0, 1, 32'h80000200, 0, 0, 0,            0, 32'h80000104, 0, 0,            0);
        add(0, 0, 0,            0, 1, 32'hBAD00100,  0, 32'h80000200, 0, 0,            0);
        add(0, 0, 0,            1, 0, 0,             1, 32'h80000200, 0, 0,            0);
        add(0, 0, 0,            0, 1, 32'h11110004,  0, 32'h80000204, 0, 0,            0);
        add(0, 0, 0,            0, 0, 0,             1, 32'h80000204, 1, 32'h80000200, 32'h11110004);
        // Slow slave: addr_ok delayed, then data_ok delayed.
        add(0, 0, 0,            0, 0, 0,             1, 32'h80000204, 0, 0,            0);
        add(0, 0, 0,            0, 0, 0,             1, 32'h80000204, 0, 0,            0);
        add(0, 0, 0,            1, 0, 0,             1, 32'h80000204, 0, 0,            0);
        add(0, 0, 0,            0, 0, 0,             0, 32'h80000208, 0, 0,            0);
        add(0, 0, 0,            0, 0, 0,             0, 32'h80000208, 0, 0,            0);
        add(0, 0, 0,            0, 0, 0,             0, 32'h80000208, 0, 0,            0);
        add(0, 0, 0,            0, 1, 32'h11110005,  0, 32'h80000208, 0, 0,            0);
        add(0, 0, 0,            0, 0, 0,             1, 32'h80000208, 1, 32'h80000204, 32'h11110005);
        // Redirect in REQ without addr_ok, then PC wraps past 2^32.
        add(0, 1, 32'hFFFFFFFC, 0, 0, 0,            1, 32'h80000208, 0, 0,            0);
        add(0, 0, 0,            1, 0, 0,             1, 32'hFFFFFFFC, 0, 0,            0);
        add(0, 0, 0,            0, 1, 32'h11110006,  0, 32'h00000000, 0, 0,            0);
        // Stray data_ok in REQ is ignored.
        add(1, 0, 0,            0, 1, 32'hBAD0BAD0,  1, 32'h00000000, 1, 32'hFFFFFFFC, 32'h11110006);
        add(0, 0, 0,            0, 0, 0,             1, 32'h00000000, 1, 32'hFFFFFFFC, 32'h11110006);
        add(0, 0, 0,            0, 0, 0,             1, 32'h00000000, 0, 0,            0);

        // Reset state
        repeat (2) @(negedge clk);
        expect_out("reset", 1'b1, 32'hBFC00000, 1'b0, 32'h0, 32'h0);
        chk("reset pc_out", pc_out, 32'h0);
        chk("reset instruction", instruction, 32'h0);
        chk("inst_wr", {31'd0, inst_wr}, 32'd0);
        chk("inst_size", {30'd0, inst_size}, 32'd2);
        rstn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            expect_out($sformatf("row%0d", i), vecs[i].e_req, vecs[i].e_addr,
                       vecs[i].e_vld, vecs[i].e_pc, vecs[i].e_ins);
            step(vecs[i].st, vecs[i].rd, vecs[i].rpc, vecs[i].aok, vecs[i].dok, vecs[i].rdata);
        end

        // Redirect while the skid is occupied drops both entries.
        expect_out("full0", 1, 32'h0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        expect_out("full1", 0, 32'h4, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'h22220000);
        expect_out("full2", 1, 32'h4, 1, 32'h0, 32'h22220000);
        step(1, 0, 0, 1, 0, 0);
        expect_out("full3", 0, 32'h8, 1, 32'h0, 32'h22220000);
        step(1, 0, 0, 0, 1, 32'h22220001);
        expect_out("full4", 0, 32'h8, 1, 32'h0, 32'h22220000);
        step(1, 1, 32'h80001000, 0, 1, 32'hBAD0F000);
        expect_out("full5", 1, 32'h80001000, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        expect_out("full6", 0, 32'h80001004, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'h22220002);
        expect_out("full7", 1, 32'h80001004, 1, 32'h80001000, 32'h22220002);
        step(0, 0, 0, 1, 0, 0);
        expect_out("full8", 0, 32'h80001008, 0, 0, 0);

        // Reset while a request is outstanding, with stray data_ok around it.
        step(0, 0, 0, 0, 1, 32'h22220003);
        expect_out("rst0", 1, 32'h80001008, 1, 32'h80001004, 32'h22220003);
        step(1, 0, 0, 1, 0, 0);
        expect_out("rst1", 0, 32'h8000100C, 1, 32'h80001004, 32'h22220003);
        rstn = 1'b0;
        drive(1, 0, 0, 0, 1, 32'hBAD0BAD1);
        #1;
        expect_out("rst2", 1, 32'hBFC00000, 0, 0, 0);
        chk("rst2 pc_out", pc_out, 32'h0);
        chk("rst2 instruction", instruction, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        step(0, 0, 0, 0, 1, 32'hBAD0BAD2);
        expect_out("rst3", 1, 32'hBFC00000, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        expect_out("rst4", 0, 32'hBFC00004, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'h22220004);
        expect_out("rst5", 1, 32'hBFC00004, 1, 32'hBFC00000, 32'h22220004);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
